// File: rtl/data_memory_be.sv
// Byte-enabled single-port data memory for the MIPS datapath: byte/half/word stores
// and loads, registered write-first read port, sequential post-reset clear.
module data_memory_be #(
    parameter int DEPTH     = 32,
    parameter int AW        = 5,
    parameter int TEST_WORD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rd,
    output logic        rd_valid,
    output logic        misaligned,
    output logic        busy,
    output logic [15:0] test_value
);

    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_IDLE  = 1'b1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] TEST_IDX = AW'(TEST_WORD);

    logic [31:0]   mem_q [DEPTH];
    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [31:0]   rd_q, rd_d;
    logic          rd_valid_q, rd_valid_d;
    logic          mis_q, mis_d;

    logic          idle;
    logic          aligned;
    logic [AW-1:0] word_idx;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic          st_write;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_idx;
    logic [3:0]    mem_wr_be;
    logic [31:0]   mem_wr_data;
    logic [31:0]   ld_word;
    logic [31:0]   ld_val;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic          unused_addr_hi;

    // Upper address bits are ignored so addresses wrap around the array.
    assign unused_addr_hi = ^A[31:AW+2];

    assign idle     = (state_q == ST_IDLE);
    assign word_idx = A[AW+1:2];
    assign aligned  = (size == 2'b00) ? 1'b1 :
                      (size == 2'b01) ? ~A[0] : (A[1:0] == 2'b00);
    assign st_write = idle && we && aligned;

    always_comb begin
        st_be   = 4'b1111;
        st_data = wd;
        case (size)
            2'b00: begin
                st_be   = 4'b0001 << A[1:0];
                st_data = {4{wd[7:0]}};
            end
            2'b01: begin
                st_be   = A[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wd[15:0]}};
            end
            default: ;
        endcase
    end

    // The clear sequence and datapath stores share the single write port.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_idx  = word_idx;
        mem_wr_be   = st_be;
        mem_wr_data = st_data;
        if (!rst) begin
            if (!idle) begin
                mem_wr_en   = 1'b1;
                mem_wr_idx  = cnt_q;
                mem_wr_be   = 4'b1111;
                mem_wr_data = 32'h0;
            end else if (st_write) begin
                mem_wr_en = 1'b1;
            end
        end
    end

    // Write-first: lanes being stored this cycle are forwarded into the load word.
    always_comb begin
        ld_word = mem_q[word_idx];
        for (int i = 0; i < 4; i++) begin
            if (st_write && st_be[i]) ld_word[8*i +: 8] = st_data[8*i +: 8];
        end
        case (A[1:0])
            2'b00:   ld_byte = ld_word[7:0];
            2'b01:   ld_byte = ld_word[15:8];
            2'b10:   ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = A[1] ? ld_word[31:16] : ld_word[15:0];
        case (size)
            2'b00:   ld_val = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{sign_ext & ld_half[15]}}, ld_half};
            default: ld_val = ld_word;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        mis_d      = 1'b0;
        if (!idle) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST_IDX) state_d = ST_IDLE;
        end else begin
            if (re) begin
                rd_valid_d = 1'b1;
                rd_d       = aligned ? ld_val : 32'h0;
            end
            mis_d = (we || re) && !aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            rd_q       <= 32'h0;
            rd_valid_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            mis_q      <= mis_d;
        end
    end

    // NOTE: the array has no reset branch; it is zeroed word by word by the clear FSM.
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wr_be[i]) mem_q[mem_wr_idx][8*i +: 8] <= mem_wr_data[8*i +: 8];
            end
        end
    end

    assign rd         = rd_q;
    assign rd_valid   = rd_valid_q;
    assign misaligned = mis_q;
    assign busy       = (state_q == ST_CLEAR);
    assign test_value = mem_q[TEST_IDX][15:0];

endmodule

// File: tb/tb_data_memory_be.sv
// Directed self-checking bench for data_memory_be (DEPTH=32, TEST_WORD=0).
module tb_data_memory_be;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] rd;
    logic        rd_valid;
    logic        misaligned;
    logic        busy;
    logic [15:0] test_value;

    int checks   = 0;
    int failures = 0;

    data_memory_be #(.DEPTH(32), .AW(5), .TEST_WORD(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .wd         (wd),
        .we         (we),
        .re         (re),
        .size       (size),
        .sign_ext   (sign_ext),
        .rd         (rd),
        .rd_valid   (rd_valid),
        .misaligned (misaligned),
        .busy       (busy),
        .test_value (test_value)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [1:0] sz,
                         input logic sx, input logic [31:0] addr, input logic [31:0] data);
        we       = w;
        re       = r;
        size     = sz;
        sign_ext = sx;
        A        = addr;
        wd       = data;
    endtask

    // Issue one load, step, and compare rd/rd_valid.
    task automatic load_check(input string name, input logic [1:0] sz, input logic sx,
                              input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b0, 1'b1, sz, sx, addr, 32'h0);
        step();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        checks++;
        if (rd !== exp || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s rd=%h rd_valid=%b expected rd=%h rd_valid=1", name, rd, rd_valid, exp);
        end
    endtask

    // Count cycles until busy falls, checking that no load is answered meanwhile.
    task automatic count_busy(input string name);
        int cycles = 0;
        int bad_valid = 0;
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        while (busy === 1'b1 && cycles < 100) begin
            step();
            cycles++;
            if (rd_valid !== 1'b0) bad_valid++;
        end
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        checks++;
        if (cycles !== 32) begin
            failures++;
            $display("FAIL %s_busy_cycles got=%0d expected=32", name, cycles);
        end
        checks++;
        if (bad_valid !== 0) begin
            failures++;
            $display("FAIL %s_rd_valid_during_busy got=%0d pulses expected=0", name, bad_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        repeat (3) step();
        checks++;
        if (rd !== 32'h0 || rd_valid !== 1'b0 || misaligned !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_state rd=%h rd_valid=%b misaligned=%b busy=%b expected 0/0/0/1",
                     rd, rd_valid, misaligned, busy);
        end
        rst = 1'b0;
        count_busy("reset");
        checks++;
        if (test_value !== 16'h0000) begin
            failures++;
            $display("FAIL reset_test_value got=%h expected=0000", test_value);
        end
        load_check("reset_word5_cleared", 2'b10, 1'b0, 32'h14, 32'h0);
    endtask

    task automatic test_word();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
        step();
        load_check("lw_word2", 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_hold rd=%h rd_valid=%b expected rd=deadbeef rd_valid=0", rd, rd_valid);
        end
    endtask

    task automatic test_byte_half();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h09, 32'h00000080);
        step();
        load_check("lb_signed",   2'b00, 1'b1, 32'h09, 32'hFFFFFF80);
        load_check("lbu",         2'b00, 1'b0, 32'h09, 32'h00000080);
        load_check("lhu_upper",   2'b01, 1'b0, 32'h0A, 32'h0000DEAD);
        load_check("lh_signed",   2'b01, 1'b1, 32'h08, 32'hFFFF80EF);
        load_check("lw_merged",   2'b10, 1'b0, 32'h08, 32'hDEAD80EF);
        load_check("lw_signext_ignored", 2'b10, 1'b1, 32'h08, 32'hDEAD80EF);
    endtask

    task automatic test_write_first();
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h00, 32'h00001234);
        step();
        checks++;
        if (rd !== 32'h00001234 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL write_first_half rd=%h rd_valid=%b expected rd=00001234 rd_valid=1", rd, rd_valid);
        end
        checks++;
        if (test_value !== 16'h1234) begin
            failures++;
            $display("FAIL test_value_after_store got=%h expected=1234", test_value);
        end
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h02, 32'h00000055);
        step();
        checks++;
        if (rd !== 32'h00000055) begin
            failures++;
            $display("FAIL write_first_byte rd=%h expected=00000055", rd);
        end
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFEF00D);
        step();
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL write_first_word rd=%h expected=cafef00d", rd);
        end
        load_check("lw_word0_merged", 2'b10, 1'b0, 32'h00, 32'h00551234);
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF);
        step();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        checks++;
        if (misaligned !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL sw_misaligned misaligned=%b rd_valid=%b expected 1/0", misaligned, rd_valid);
        end
        load_check("sw_misaligned_no_write", 2'b10, 1'b0, 32'h04, 32'hCAFEF00D);
        checks++;
        if (misaligned !== 1'b0) begin
            failures++;
            $display("FAIL aligned_load_misaligned got=%b expected=0", misaligned);
        end
        load_check("lh_misaligned_rd", 2'b01, 1'b1, 32'h03, 32'h0);
        checks++;
        if (misaligned !== 1'b1) begin
            failures++;
            $display("FAIL lh_misaligned_flag got=%b expected=1", misaligned);
        end
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h01, 32'h0000BEEF);
        step();
        checks++;
        if (misaligned !== 1'b1) begin
            failures++;
            $display("FAIL sh_misaligned_flag got=%b expected=1", misaligned);
        end
        load_check("sh_misaligned_no_write", 2'b10, 1'b0, 32'h00, 32'h00551234);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h13572468);
        step();
        load_check("sw_wrap_word0", 2'b10, 1'b0, 32'h00, 32'h13572468);
        checks++;
        if (test_value !== 16'h2468) begin
            failures++;
            $display("FAIL wrap_test_value got=%h expected=2468", test_value);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h11A23344);
        step();
        load_check("b2b_lb0", 2'b00, 1'b1, 32'h0C, 32'h00000044);
        drive(1'b0, 1'b1, 2'b00, 1'b1, 32'h0D, 32'h0);
        step();
        checks++;
        if (rd !== 32'h00000033) begin
            failures++;
            $display("FAIL b2b_lb1 rd=%h expected=00000033", rd);
        end
        drive(1'b0, 1'b1, 2'b00, 1'b1, 32'h0E, 32'h0);
        step();
        checks++;
        if (rd !== 32'hFFFFFFA2 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_lb2 rd=%h rd_valid=%b expected rd=ffffffa2 rd_valid=1", rd, rd_valid);
        end
        load_check("b2b_lb3", 2'b00, 1'b1, 32'h0F, 32'h00000011);
    endtask

    task automatic test_mid_clear();
        int bad_busy = 0;
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h00, 32'h00001234);
        step();
        checks++;
        if (test_value !== 16'h1234) begin
            failures++;
            $display("FAIL pre_clear_test_value got=%h expected=1234", test_value);
        end
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) begin
            step();
            if (busy !== 1'b1) bad_busy++;
        end
        checks++;
        if (bad_busy !== 0) begin
            failures++;
            $display("FAIL mid_clear_busy_low got=%0d low cycles expected=0", bad_busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("restart");
        load_check("restart_word0_cleared", 2'b10, 1'b0, 32'h00, 32'h0);
        load_check("restart_word3_cleared", 2'b10, 1'b0, 32'h0C, 32'h0);
        checks++;
        if (test_value !== 16'h0000) begin
            failures++;
            $display("FAIL restart_test_value got=%h expected=0000", test_value);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_word();
        test_byte_half();
        test_write_first();
        test_misaligned();
        test_back_to_back();
        test_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
- Parametrised successor of the MIPS single-port data memory, adding byte/halfword/word stores and loads with optional sign extension.
- Read port is registered, with one-cycle latency and write-first behaviour.
- Clearing after reset is sequential, one word per cycle; `busy` is asserted while it runs.
- Misaligned accesses are detected and reported.
- Sits between the MIPS datapath ALU result/rt bus and the writeback mux; also exports a debug halfword.

Parameters:
- DEPTH, 32: number of 32-bit words; power of two, 4..4096.
- AW, 5: word-index width, equal to log2(DEPTH).
- TEST_WORD, 0: word index exported on `test_value`.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high; starts a clear sequence.
- A  in  32  byte address; word index = A[AW+1:2], bits above AW+1 ignored (wrap-around).
- wd  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- we  in  1  store request.
- re  in  1  load request.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- sign_ext  in  1  loads only; 1 = sign-extend byte/half, 0 = zero-extend.
- rd  out  32  load data, registered.
- rd_valid  out  1  one-cycle pulse; `rd` is valid in that cycle.
- misaligned  out  1  one-cycle pulse; the previous cycle's access was misaligned.
- busy  out  1  clear sequence in progress; requests ignored.
- test_value  out  16  data_m[TEST_WORD][15:0], combinational from the array.

Behaviour:
- Reset:
  - While rst=1: rd=0, rd_valid=0, misaligned=0, busy=1, clear counter=0, FSM in CLEAR.
  - Array contents are undefined until the clear sequence finishes.
- FSM CLEAR:
  - Each cycle with rst=0, write 0 to word[counter], then counter+1.
  - When counter=DEPTH-1 is written, the next state is IDLE and busy falls on the following edge.
  - busy is therefore high for exactly DEPTH cycles after rst deasserts.
  - Asserting rst mid-clear restarts at counter 0.
  - we/re are ignored in CLEAR: no write, no rd_valid.
- FSM IDLE: requests are accepted every cycle. rst=1 returns the FSM to CLEAR from any state.
- Alignment:
  - half requires A[0]=0; word requires A[1:0]=00; byte is always aligned.
  - A misaligned access (we or re) suppresses the write.
  - For a misaligned load: rd=0 and rd_valid=1 on the next cycle.
  - misaligned=1 on the next cycle for a misaligned access, whether load, store or both.
- Store:
  - Byte lane = A[1:0]; half lane = A[1].
  - Only the addressed lanes of the word are updated at the rising edge; the other lanes are unchanged.
- Load:
  - The word is selected and the lane extracted per size/A[1:0].
  - Extension per sign_ext (word ignores sign_ext).
  - Result registered: rd/rd_valid appear 1 cycle after re.
  - rd holds its last value when rd_valid=0.
- Simultaneous we and re to the same word: write-first. The load returns the merged post-store word.
- Different words with we and re: the load returns the old contents of its word.
- test_value reflects a store to TEST_WORD from the cycle after the store edge.

Test Plan:
- Reset sequence: rst=1 for 3 cycles, then 0 -> busy=1 for exactly 32 cycles, then 0; test_value=0x0000; a re issued during busy gives no rd_valid.
- Word store and load: sw A=0x08 wd=0xDEADBEEF, then lw A=0x08 -> next cycle rd=0xDEADBEEF, rd_valid=1.
- Byte store and signed/unsigned loads:
  - Start from word 2=0xDEADBEEF, sb A=0x09 wd=0x00000080 -> word=0xDEAD80EF.
  - lb A=0x09 sign_ext=1 -> rd=0xFFFFFF80.
  - lbu A=0x09 -> rd=0x00000080.
  - lhu A=0x0A -> rd=0x0000DEAD.
- Write-first: same cycle sh A=0x00 wd=0x1234 and lw A=0x00 on a cleared word -> rd=0x00001234; test_value=0x1234 the following cycle.
- Misalignment and wrap:
  - sw A=0x06 -> misaligned=1 next cycle, memory unchanged.
  - lh A=0x03 -> rd=0, rd_valid=1, misaligned=1.
  - sw A=0x80 with DEPTH=32 -> word 0 written.
- Reset mid-clear: assert rst at clear cycle 10 for 1 cycle -> busy stays high 32 cycles from the deassertion; word 0 earlier holding 0x1234 reads 0 afterwards.
